// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-port memory between
// instruction fetch and data access, with a fixed wait-state count.
module mem_arb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_dm_q;
  logic        pick_dm, pick_if, grant, last_acc;
  logic        we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rd_q, dm_rd_q;

  // last_dm_q doubles as the grant owner for the access in flight
  assign pick_dm  = dm_req & (~if_req | ~last_dm_q);
  assign pick_if  = if_req & ~pick_dm;
  assign grant    = (state_q == IDLE) & (pick_if | pick_dm);
  assign last_acc = (state_q == ACCESS) & (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LD;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else cnt_d = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      last_dm_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_rd_q   <= '0;
      dm_rd_q   <= '0;
    end else begin
      if (grant) begin
        last_dm_q <= pick_dm;
        we_q      <= pick_dm & dm_we;
        addr_q    <= pick_dm ? dm_addr : if_addr;
        wdata_q   <= pick_dm ? dm_wdata : '0;
      end
      if (last_acc) begin
        we_q <= 1'b0;
        if (!we_q) begin
          if (last_dm_q) dm_rd_q <= mem_rdata;
          else if_rd_q <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_en = 1'b0;
    if_ack = 1'b0;
    dm_ack = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      ACCESS: begin
        mem_en = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        if_ack = ~last_dm_q;
        dm_ack = last_dm_q;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rd_q;
  assign dm_rdata  = dm_rd_q;

endmodule

// File: tb/tb_mem_arb.sv
// Random and directed stimulus for mem_arb against a
// transaction-level timeline model.
module tb_mem_arb;

  localparam int W = 1;

  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, busy;

  logic        if_req0 = 1'b0, dm_req0 = 1'b0;
  logic        dm_we0 = 1'b0;
  logic [31:0] zero0 = '0;
  logic [31:0] mem_rdata0 = 32'h1234_5678;
  logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0;
  logic        if_ack0, dm_ack0, mem_en0, mem_we0, busy0;

  mem_arb #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .RST(RST),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arb #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .RST(RST),
    .if_req(if_req0), .if_addr(zero0),
    .if_rdata(if_rdata0), .if_ack(if_ack0),
    .dm_req(dm_req0), .dm_we(dm_we0),
    .dm_addr(zero0), .dm_wdata(zero0),
    .dm_rdata(dm_rdata0), .dm_ack(dm_ack0),
    .mem_en(mem_en0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  // behavioural single-port memory behind the arbiter
  logic [31:0] tbmem [16];
  logic [31:0] seed  [16];
  logic        init_mem = 1'b0;
  assign mem_rdata = tbmem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= seed[i];
    end else if (mem_en && mem_we) begin
      tbmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: one transaction at a time on a cycle timeline
  logic [31:0] mm [16];
  int          cyc = 0;
  int          m_g = 0;
  bit          m_act = 0, m_dm = 0, m_we = 0;
  bit          m_last_dm = 0, grant_ok = 1;
  bit          saw_if = 0, saw_dm = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_val = '0;
  logic [31:0] e_if_rd = '0, e_dm_rd = '0;

  task automatic step_check();
    bit acc, dn;
    acc = m_act && cyc >= m_g + 1 && cyc <= m_g + W + 1;
    dn  = m_act && cyc == m_g + W + 2;
    if (dn && !m_we) begin
      if (m_dm) e_dm_rd = m_val;
      else e_if_rd = m_val;
    end
    chk("mem_en", 32'(mem_en), 32'(acc));
    chk("mem_we", 32'(mem_we), 32'(acc && m_we));
    chk("busy", 32'(busy), 32'(acc || dn));
    chk("if_ack", 32'(if_ack), 32'(dn && !m_dm));
    chk("dm_ack", 32'(dm_ack), 32'(dn && m_dm));
    chk("dual_ack", 32'(if_ack && dm_ack), 32'd0);
    chk("if_rdata", if_rdata, e_if_rd);
    chk("dm_rdata", dm_rdata, e_dm_rd);
    if (acc) begin
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    saw_if   = if_ack;
    saw_dm   = dm_ack;
    grant_ok = !m_act;
    if (dn) m_act = 0;
  endtask

  task automatic step_model();
    if (grant_ok && (if_req || dm_req)) begin
      if (if_req && dm_req) m_dm = !m_last_dm;
      else m_dm = dm_req;
      m_last_dm = m_dm;
      m_act   = 1;
      m_g     = cyc;
      m_we    = m_dm && dm_we;
      m_addr  = m_dm ? dm_addr : if_addr;
      m_wdata = dm_wdata;
      m_val   = mm[m_addr[5:2]];
      if (m_we) mm[m_addr[5:2]] = m_wdata;
    end
  endtask

  task automatic tick();
    step_model();
    @(posedge clk);
    #1;
    cyc++;
    step_check();
  endtask

  initial begin
    int lat, en, nack, n;
    bit if_pend, dm_pend, prev, kind;
    logic [31:0] prev_rd;
    int order[$];

    for (int i = 0; i < 16; i++) begin
      seed[i] = $urandom;
      mm[i]   = seed[i];
    end
    seed[1] = 32'h0800_0003;
    mm[1]   = 32'h0800_0003;

    // both requests held through reset
    if_req   = 1'b1;
    if_addr  = 32'h8;
    dm_req   = 1'b1;
    dm_addr  = 32'hC;
    init_mem = 1'b1;
    @(posedge clk);
    #1 init_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ifack", 32'(if_ack), 32'd0);
    chk("rst_dmack", 32'(dm_ack), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ifrd", if_rdata, 32'd0);
    chk("rst_dmrd", dm_rdata, 32'd0);
    @(negedge clk);
    RST = 1'b1;

    // tie after reset: dm first, then strict alternation
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      tick();
      if (saw_dm) begin
        order.push_back(1);
        dm_addr = 32'({$urandom_range(0, 15), 2'b00});
      end
      if (saw_if) begin
        order.push_back(0);
        if_addr = 32'({$urandom_range(0, 15), 2'b00});
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk("rr_order", 32'(order[i]), 32'((i % 2) == 0));

    // single fetch latency and data
    tick();
    if_req  = 1'b1;
    if_addr = 32'h4;
    lat = 0;
    en  = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_en) en++;
      if (saw_if) begin
        lat = i;
        if_req = 1'b0;
        break;
      end
    end
    chk("if_lat", 32'(lat), 32'(W + 2));
    chk("if_en_cyc", 32'(en), 32'(W + 1));
    chk("if_rd_val", if_rdata, 32'h0800_0003);

    // store leaves dm_rdata alone
    tick();
    prev_rd  = e_dm_rd;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h10;
    dm_wdata = 32'hDEAD_BEEF;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (saw_dm) begin
        nack++;
        dm_req = 1'b0;
      end
    end
    dm_we = 1'b0;
    chk("st_acks", 32'(nack), 32'd1);
    chk("st_rdata", dm_rdata, prev_rd);
    chk("st_mem", tbmem[4], 32'hDEAD_BEEF);

    // reset in the middle of an access
    if_req  = 1'b1;
    if_addr = 32'h8;
    tick();
    tick();
    #1 RST = 1'b0;
    #1;
    chk("abort_en", 32'(mem_en), 32'd0);
    chk("abort_ifack", 32'(if_ack), 32'd0);
    chk("abort_dmack", 32'(dm_ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    #1 RST = 1'b1;
    m_act     = 0;
    m_last_dm = 0;
    e_if_rd   = '0;
    e_dm_rd   = '0;
    grant_ok  = 1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (saw_if) begin
        lat = i;
        if_req = 1'b0;
        break;
      end
    end
    chk("abort_relat", 32'(lat), 32'(W + 2));
    chk("abort_rd", if_rdata, mm[2]);

    // random traffic, occasional early request drop
    if_pend = 0;
    dm_pend = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (saw_if) if_pend = 0;
      if (saw_dm) dm_pend = 0;
      if (if_pend && $urandom_range(0, 99) == 0) if_pend = 0;
      if (dm_pend && $urandom_range(0, 99) == 0) dm_pend = 0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        if_addr = 32'({$urandom_range(0, 15), 2'b00});
      end
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend  = 1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 32'({$urandom_range(0, 15), 2'b00});
        dm_wdata = $urandom;
      end
      if_req = if_pend;
      dm_req = dm_pend;
    end
    if_req = 1'b0;
    dm_req = 1'b0;

    // zero wait states: continuous fetch, then contention
    @(posedge clk);
    #1 if_req0 = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk);
      #1;
      chk("w0_if_ack", 32'(if_ack0), 32'((j % 3) == 2));
      chk("w0_dm_ack", 32'(dm_ack0), 32'd0);
      if (if_ack0) chk("w0_rdata", if_rdata0, 32'h1234_5678);
    end
    dm_req0 = 1'b1;
    prev = 0;
    n    = 0;
    for (int j = 31; j <= 60; j++) begin
      @(posedge clk);
      #1;
      chk("w0_dual", 32'(if_ack0 && dm_ack0), 32'd0);
      chk("w0_period", 32'(if_ack0 || dm_ack0), 32'((j % 3) == 2));
      if (if_ack0 || dm_ack0) begin
        kind = dm_ack0;
        chk("w0_alt", 32'(kind), 32'(!prev));
        prev = kind;
        n++;
      end
    end
    chk("w0_cnt", 32'(n), 32'd10);
    if_req0 = 1'b0;
    dm_req0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: ADDR_W, default 32, address width in bits.
REQ-002 Parameter: DATA_W, default 32, data width in bits.
REQ-003 Parameter: WAIT_CYCLES, default 1, extra memory latency cycles per access (0..15).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and RST.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 RST  in  1  asynchronous active-low reset.
REQ-007 if_req  in  1  instruction-fetch request; held high until if_ack.
REQ-008 if_addr  in  ADDR_W  fetch address; stable while if_req is high.
REQ-009 if_rdata  out  DATA_W  fetched instruction; valid in the if_ack cycle.
REQ-010 if_ack  out  1  one-cycle fetch completion pulse.
REQ-011 dm_req  in  1  data-memory request; held high until dm_ack.
REQ-012 dm_we  in  1  1 = store (sw), 0 = load (lw); stable while dm_req is high.
REQ-013 dm_addr  in  ADDR_W  data address.
REQ-014 dm_wdata  in  DATA_W  store data.
REQ-015 dm_rdata  out  DATA_W  load data; valid in the dm_ack cycle.
REQ-016 dm_ack  out  1  one-cycle data completion pulse.
REQ-017 mem_en  out  1  shared single-port memory enable.
REQ-018 mem_we  out  1  shared memory write enable.
REQ-019 mem_addr  out  ADDR_W  shared memory address.
REQ-020 mem_wdata  out  DATA_W  shared memory write data.
REQ-021 mem_rdata  in  DATA_W  shared memory read data; valid WAIT_CYCLES+1 cycles after mem_en first rises.
REQ-022 busy  out  1  high in any state other than IDLE.

Function
REQ-023 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-024 IDLE: if exactly one request is high, that requester SHALL be granted and the FSM SHALL move to ACCESS on the next edge.
REQ-025 Tie in IDLE (if_req and dm_req both high): the requester not served last (flag last_gnt) SHALL win, giving round-robin service.
REQ-026 On grant, the block SHALL register the selected address, write data and write enable into mem_addr, mem_wdata and mem_we, and set last_gnt to the winner.
REQ-027 ACCESS: mem_en SHALL be high; a 4-bit wait counter SHALL load WAIT_CYCLES on entry and decrement each cycle; the FSM SHALL leave ACCESS for DONE on the cycle the counter equals 0.
REQ-028 A fetch grant SHALL force mem_we = 0.
REQ-029 On the ACCESS-to-DONE edge, the block SHALL capture mem_rdata into the granted requester's rdata register; on a store, rdata SHALL keep its previous value.
REQ-030 DONE: the granted requester's ack SHALL be high for exactly one cycle, mem_en and mem_we SHALL be 0, and the FSM SHALL return to IDLE.
REQ-031 Latency, request high in IDLE to ack: WAIT_CYCLES+2 cycles with no contention; the loser of a tie waits one additional full transaction.
REQ-032 A request already high during DONE SHALL be evaluated in the following IDLE cycle; the block SHALL NOT issue back-to-back grants without an IDLE cycle between them.
REQ-033 Requester inputs SHALL be ignored outside IDLE.
REQ-034 A request that drops before its ack is a protocol error; the in-flight access SHALL still complete and ack.
REQ-035 if_ack and dm_ack SHALL never be high in the same cycle.
REQ-036 Address and data outputs SHALL be registered, with no combinational path from request inputs to mem_* outputs.

Reset
REQ-037 While RST = 0, the FSM SHALL be IDLE, all outputs SHALL be 0, the counter SHALL be 0 and last_gnt SHALL equal fetch, so that data wins the first tie.
REQ-038 Reset asserted mid-ACCESS SHALL abort the access immediately with no ack and no further mem_en.
REQ-039 After RST is released, the first grant SHALL occur no earlier than the first rising edge of clk.

Verification
REQ-040 WAIT_CYCLES=1: if_req with if_addr=0x0000_0004 and mem_rdata=0x0800_0003 -> mem_en high for 2 cycles, if_ack on cycle 3, if_rdata=0x0800_0003.
REQ-041 Store: dm_req, dm_we=1, dm_addr=0x10, dm_wdata=0xDEAD_BEEF -> mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD_BEEF during ACCESS, dm_ack once, dm_rdata unchanged.
REQ-042 Tie after reset, both requests held -> dm served first, then if; with a further tie, dm is served next only if if was served last (alternation checked over 4 transactions).
REQ-043 RST pulled low during ACCESS -> mem_en=0 and no ack in the same cycle; after release, if the request is still held, a fresh full-latency access occurs.
REQ-044 WAIT_CYCLES=0 with continuous if_req -> ack every 3 cycles (ACCESS, DONE, IDLE); if_ack and dm_ack never coincide.
